mini_alu_gen2: RTL and testbench

Parametrised second-generation mini processor core: two-stage (fetch / execute) machine with an external instruction port, an internal dual-read register RAM with write-forwarding, an extended ALU opcode set, call/return, halt, and a valid/ready output port alongside the LED register. It replaces the fixed 16-bit core at the top of the lab design. An external ROM drives iInstruction combinationally from oIP.

---
 rtl/mini_alu_gen2_if.sv | 24 ++
 rtl/mini_alu_gen2.sv | 127 ++++++++++++
 tb/tb_mini_alu_gen2.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mini_alu_gen2_if.sv
// rtl/mini_alu_gen2_if.sv - core bus: instruction fetch, LED, output stream and halt status
interface mini_alu_gen2_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IP_WIDTH   = 16
);
  logic [IP_WIDTH-1:0]       ip;
  logic [4+3*ADDR_WIDTH-1:0] instruction;
  logic [7:0]                led;
  logic [DATA_WIDTH-1:0]     out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      halted;

  modport master (
    output ip, led, out_data, out_valid, halted,
    input  instruction, out_ready
  );

  modport slave (
    input  ip, led, out_data, out_valid, halted,
    output instruction, out_ready
  );
endinterface

// File: rtl/mini_alu_gen2.sv
// rtl/mini_alu_gen2.sv - two-stage fetch/execute mini core with forwarding register RAM,
// call/return, halt and a one-entry valid/ready output register
module mini_alu_gen2 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IP_WIDTH   = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mini_alu_gen2_if.master bus_io
);
  localparam logic [3:0] OP_NOP  = 4'h0, OP_LED  = 4'h1, OP_STO  = 4'h2, OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4, OP_AND  = 4'h5, OP_OR   = 4'h6, OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8, OP_BLE  = 4'h9, OP_BLES = 4'hA, OP_JMP  = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC, OP_RET  = 4'hD, OP_OUT  = 4'hE, OP_HALT = 4'hF;
  localparam logic [DATA_WIDTH-1:0] SHIFT_LIMIT = DATA_WIDTH'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] ram_q [2**ADDR_WIDTH];

  logic [IP_WIDTH-1:0]   pc_q, pc_d, link_q, link_d, fetch_ip;
  logic [3:0]            ex_op_q, ex_op_d;
  logic [ADDR_WIDTH-1:0] ex_dest_q, ex_dest_d, ex_src1_q, ex_src1_d, ex_src0_q, ex_src0_d;
  logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [7:0]            led_q, led_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d, halted_q, halted_d;

  logic [3:0]            f_op;
  logic [ADDR_WIDTH-1:0] f_dest, f_src1, f_src0;
  logic                  branch_taken, stall, freeze, wr_en, out_load;
  logic [DATA_WIDTH-1:0] wr_data;

  assign {f_op, f_dest, f_src1, f_src0} = bus_io.instruction;

  always_comb begin
    branch_taken = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    case (ex_op_q)
      OP_STO:  begin wr_en = 1'b1; wr_data = DATA_WIDTH'({ex_src1_q, ex_src0_q}); end
      OP_ADD:  begin wr_en = 1'b1; wr_data = d1_q + d0_q; end
      OP_SUB:  begin wr_en = 1'b1; wr_data = d1_q - d0_q; end
      OP_AND:  begin wr_en = 1'b1; wr_data = d1_q & d0_q; end
      OP_OR:   begin wr_en = 1'b1; wr_data = d1_q | d0_q; end
      OP_XOR:  begin wr_en = 1'b1; wr_data = d1_q ^ d0_q; end
      OP_SHL:  begin wr_en = 1'b1; wr_data = (d0_q >= SHIFT_LIMIT) ? '0 : (d1_q << d0_q); end
      OP_BLE:  branch_taken = (d1_q <= d0_q);
      OP_BLES: branch_taken = ($signed(d1_q) <= $signed(d0_q));
      OP_JMP, OP_CALL, OP_RET: branch_taken = 1'b1;
      default: ;
    endcase
  end

  // Taken branches redirect fetch in the same cycle, so there is no bubble or delay slot.
  assign fetch_ip  = branch_taken ? ((ex_op_q == OP_RET) ? link_q : IP_WIDTH'(ex_dest_q)) : pc_q;
  assign stall     = (ex_op_q == OP_OUT) && out_valid_q && !bus_io.out_ready;
  assign freeze    = halted_q || (ex_op_q == OP_HALT);
  assign out_load  = (ex_op_q == OP_OUT) && !stall;

  always_comb begin
    pc_d      = pc_q;
    ex_op_d   = ex_op_q;
    ex_dest_d = ex_dest_q;
    ex_src1_d = ex_src1_q;
    ex_src0_d = ex_src0_q;
    d0_d      = d0_q;
    d1_d      = d1_q;
    if (!stall) begin
      ex_op_d   = freeze ? OP_NOP : f_op;
      ex_dest_d = f_dest;
      ex_src1_d = f_src1;
      ex_src0_d = f_src0;
      d0_d      = (wr_en && (ex_dest_q == f_src0)) ? wr_data : ram_q[f_src0];
      d1_d      = (wr_en && (ex_dest_q == f_src1)) ? wr_data : ram_q[f_src1];
      if (!freeze)
        pc_d = fetch_ip + IP_WIDTH'(1);
    end
  end

  // While a CALL executes, pc_q already holds the CALL's own IP plus one.
  assign link_d      = (ex_op_q == OP_CALL) ? pc_q : link_q;
  assign led_d       = (ex_op_q == OP_LED) ? d1_q[7:0] : led_q;
  assign out_valid_d = out_load || (out_valid_q && !bus_io.out_ready);
  assign out_data_d  = out_load ? d1_q : out_data_q;
  assign halted_d    = halted_q || (ex_op_q == OP_HALT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= '0;
      link_q      <= '0;
      ex_op_q     <= OP_NOP;
      ex_dest_q   <= '0;
      ex_src1_q   <= '0;
      ex_src0_q   <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      led_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      link_q      <= link_d;
      ex_op_q     <= ex_op_d;
      ex_dest_q   <= ex_dest_d;
      ex_src1_q   <= ex_src1_d;
      ex_src0_q   <= ex_src0_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      led_q       <= led_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en)
      ram_q[ex_dest_q] <= wr_data;
  end

  assign bus_io.ip        = fetch_ip;
  assign bus_io.led       = led_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.halted    = halted_q;
endmodule

// File: tb/tb_mini_alu_gen2.sv
// tb/tb_mini_alu_gen2.sv - directed program run against an instruction-level model of the core
module tb_mini_alu_gen2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mini_alu_gen2_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .IP_WIDTH(16)) bus_if ();

  mini_alu_gen2 #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .IP_WIDTH(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus_if)
  );

  logic [27:0] rom [256];
  assign bus_if.instruction = rom[bus_if.ip[7:0]];
  assign bus_if.out_ready   = ready;

  function automatic logic [27:0] enc(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
    return {4'h2, d, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ip(input logic [15:0] ip, input string name);
    int n = 0;
    while (bus_if.ip !== ip && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check(name, 32'(bus_if.ip), 32'(ip));
  endtask

  // Instruction-level model: architectural register file, one instruction in execute.
  logic [15:0] m_ram [256];
  logic [27:0] m_ex;
  logic [15:0] m_pc, m_ex_ip, m_link, m_od, a, b, exp_ip;
  logic [7:0]  m_led, dest, s1, s0;
  logic [3:0]  op;
  logic        m_ov, m_halt, taken, m_stall, was_halt;
  logic [15:0] seen [$];

  always @(negedge clk) begin
    if (rst) begin
      m_pc = '0; m_ex = '0; m_ex_ip = '0; m_link = '0;
      m_led = '0; m_od = '0; m_ov = 1'b0; m_halt = 1'b0;
    end else begin
      {op, dest, s1, s0} = m_ex;
      a = m_ram[s1];
      b = m_ram[s0];
      case (op)
        4'h9:          taken = (a <= b);
        4'hA:          taken = ($signed(a) <= $signed(b));
        4'hB, 4'hC, 4'hD: taken = 1'b1;
        default:       taken = 1'b0;
      endcase
      exp_ip = taken ? ((op == 4'hD) ? m_link : {8'h00, dest}) : m_pc;
      check("ip", 32'(bus_if.ip), 32'(exp_ip));
      check("led", 32'(bus_if.led), 32'(m_led));
      check("out_valid", 32'(bus_if.out_valid), 32'(m_ov));
      check("out_data", 32'(bus_if.out_data), 32'(m_od));
      check("halted", 32'(bus_if.halted), 32'(m_halt));
      if (bus_if.out_valid && ready)
        seen.push_back(bus_if.out_data);

      m_stall  = (op == 4'hE) && m_ov && !ready;
      was_halt = m_halt;
      if (m_ov && ready)
        m_ov = 1'b0;
      if (!m_stall) begin
        case (op)
          4'h1: m_led = a[7:0];
          4'h2: m_ram[dest] = {s1, s0};
          4'h3: m_ram[dest] = a + b;
          4'h4: m_ram[dest] = a - b;
          4'h5: m_ram[dest] = a & b;
          4'h6: m_ram[dest] = a | b;
          4'h7: m_ram[dest] = a ^ b;
          4'h8: m_ram[dest] = (b >= 16) ? 16'h0 : (a << b);
          4'hC: m_link = m_ex_ip + 16'd1;
          4'hE: begin m_od = a; m_ov = 1'b1; end
          4'hF: m_halt = 1'b1;
          default: ;
        endcase
        if (was_halt || op == 4'hF) begin
          m_ex = '0;
        end else begin
          m_ex    = rom[exp_ip[7:0]];
          m_ex_ip = exp_ip;
          m_pc    = exp_ip + 16'd1;
        end
      end
    end
  end

  logic [15:0] exp_out [9];

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]   = '0;
      m_ram[i] = '0;
    end
    rom[8'h00] = sto(8'd1, 16'd5);
    rom[8'h01] = sto(8'd2, 16'd7);
    rom[8'h02] = enc(4'h3, 8'd3, 8'd2, 8'd1);
    rom[8'h03] = enc(4'h1, 8'd0, 8'd3, 8'd0);
    rom[8'h04] = sto(8'd6, 16'd0);
    rom[8'h05] = enc(4'hC, 8'h20, 8'd0, 8'd0);
    rom[8'h06] = enc(4'hB, 8'h40, 8'd0, 8'd0);
    rom[8'h10] = enc(4'hF, 8'd0, 8'd0, 8'd0);
    rom[8'h11] = enc(4'h1, 8'd0, 8'd16, 8'd0);
    rom[8'h20] = sto(8'd7, 16'h0077);
    rom[8'h21] = enc(4'hD, 8'd0, 8'd0, 8'd0);
    rom[8'h40] = sto(8'd1, 16'h00FF);
    rom[8'h41] = enc(4'h3, 8'd2, 8'd1, 8'd1);
    rom[8'h42] = enc(4'hE, 8'd0, 8'd2, 8'd0);
    rom[8'h43] = sto(8'd1, 16'd0);
    rom[8'h44] = sto(8'd2, 16'd3);
    rom[8'h45] = sto(8'd3, 16'd1);
    rom[8'h46] = enc(4'h3, 8'd1, 8'd1, 8'd3);
    rom[8'h47] = enc(4'h9, 8'h46, 8'd1, 8'd2);
    rom[8'h48] = enc(4'hE, 8'd0, 8'd1, 8'd0);
    rom[8'h49] = sto(8'd4, 16'hFFFF);
    rom[8'h4A] = sto(8'd5, 16'd1);
    rom[8'h4B] = enc(4'hA, 8'h4D, 8'd4, 8'd5);
    rom[8'h4C] = enc(4'hE, 8'd0, 8'd4, 8'd0);
    rom[8'h4D] = enc(4'h9, 8'h4F, 8'd4, 8'd5);
    rom[8'h4E] = enc(4'hB, 8'h50, 8'd0, 8'd0);
    rom[8'h4F] = enc(4'hE, 8'd0, 8'd5, 8'd0);
    rom[8'h50] = sto(8'd6, 16'd1);
    rom[8'h51] = sto(8'd7, 16'd16);
    rom[8'h52] = enc(4'h8, 8'd8, 8'd6, 8'd7);
    rom[8'h53] = enc(4'hE, 8'd0, 8'd8, 8'd0);
    rom[8'h54] = sto(8'd9, 16'd0);
    rom[8'h55] = enc(4'h4, 8'd10, 8'd9, 8'd6);
    rom[8'h56] = enc(4'hE, 8'd0, 8'd10, 8'd0);
    rom[8'h57] = sto(8'd11, 16'h0F0F);
    rom[8'h58] = sto(8'd12, 16'h00FF);
    rom[8'h59] = enc(4'h5, 8'd13, 8'd11, 8'd12);
    rom[8'h5A] = enc(4'h6, 8'd14, 8'd11, 8'd12);
    rom[8'h5B] = enc(4'h7, 8'd15, 8'd11, 8'd12);
    rom[8'h5C] = enc(4'hE, 8'd0, 8'd13, 8'd0);
    rom[8'h5D] = enc(4'hE, 8'd0, 8'd14, 8'd0);
    rom[8'h5E] = enc(4'hE, 8'd0, 8'd15, 8'd0);
    rom[8'h5F] = sto(8'd16, 16'hAAAA);
    rom[8'h60] = sto(8'd17, 16'h5555);
    rom[8'h61] = enc(4'hE, 8'd0, 8'd16, 8'd0);
    rom[8'h62] = enc(4'hE, 8'd0, 8'd17, 8'd0);
    rom[8'h63] = enc(4'h1, 8'd0, 8'd6, 8'd0);
    rom[8'h64] = enc(4'hB, 8'h10, 8'd0, 8'd0);
    exp_out = '{16'h01FE, 16'h0004, 16'h0000, 16'hFFFF, 16'h000F,
                16'h0FFF, 16'h0FF0, 16'hAAAA, 16'h5555};

    #1;
    check("rst_ip", 32'(bus_if.ip), 32'h0);
    check("rst_led", 32'(bus_if.led), 32'h0);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'h0);
    check("rst_halted", 32'(bus_if.halted), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("seq_ip0", 32'(bus_if.ip), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("seq_ip%0d", k), 32'(bus_if.ip), 32'(k));
    end
    check("led_add", 32'(bus_if.led), 32'd12);
    @(posedge clk); #1 check("call_target", 32'(bus_if.ip), 32'h20);
    @(posedge clk); #1 check("sub_next", 32'(bus_if.ip), 32'h21);
    @(posedge clk); #1 check("ret_link", 32'(bus_if.ip), 32'h06);

    wait_ip(16'h0062, "reach_out2");
    ready = 1'b0;
    @(posedge clk); #1;
    check("stall_ip_a", 32'(bus_if.ip), 32'h63);
    check("stall_data_a", 32'(bus_if.out_data), 32'hAAAA);
    check("stall_valid_a", 32'(bus_if.out_valid), 32'h1);
    @(posedge clk); #1;
    check("stall_ip_b", 32'(bus_if.ip), 32'h63);
    @(posedge clk); #1;
    ready = 1'b1;

    begin
      int n = 0;
      while (!bus_if.halted && n < 200) begin
        @(posedge clk); #1; n++;
      end
    end
    check("halted", 32'(bus_if.halted), 32'h1);
    check("halt_ip", 32'(bus_if.ip), 32'h11);
    check("halt_led", 32'(bus_if.led), 32'h1);
    repeat (5) @(posedge clk);
    #1 check("halt_led_hold", 32'(bus_if.led), 32'h1);
    check("halt_hold", 32'(bus_if.halted), 32'h1);

    #2 rst = 1'b1;
    #1;
    check("async_ip", 32'(bus_if.ip), 32'h0);
    check("async_led", 32'(bus_if.led), 32'h0);
    check("async_data", 32'(bus_if.out_data), 32'h0);
    check("async_valid", 32'(bus_if.out_valid), 32'h0);
    check("async_halted", 32'(bus_if.halted), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("restart_ip", 32'(bus_if.ip), 32'h0);
    @(posedge clk); #1 check("restart_ip1", 32'(bus_if.ip), 32'h1);
    repeat (6) @(posedge clk);
    #1;

    check("out_count", 32'(seen.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < seen.size())
        check($sformatf("out_word%0d", i), 32'(seen[i]), 32'(exp_out[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
